// File: rtl/game_pkg.sv
// Shared types and defaults for the Flappy Bird game-flow controller.
// Holds the state encoding, BCD geometry and a digit-wise BCD compare.
package game_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StPlaying  = 2'd1,
      StDying    = 2'd2,
      StGameOver = 2'd3
   } game_state_e;

   localparam int unsigned BcdDigitW = 4;
   localparam int unsigned BcdDigits = 4;

   localparam int unsigned DefDeathFrames    = 60;
   localparam int unsigned DefOverHoldFrames = 30;
   localparam int unsigned DefFloorY         = 470;
   localparam int unsigned DefCeilY          = 0;

   // The first differing digit, scanned from the most significant, decides.
   function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
      logic decided;
      logic gt;
      decided = 1'b0;
      gt      = 1'b0;
      for (int i = int'(BcdDigits) - 1; i >= 0; i--) begin
         if (!decided && (a[i*BcdDigitW +: BcdDigitW] != b[i*BcdDigitW +: BcdDigitW])) begin
            decided = 1'b1;
            gt      = a[i*BcdDigitW +: BcdDigitW] > b[i*BcdDigitW +: BcdDigitW];
         end
      end
      return gt;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4 import game_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        inc,
   output logic [15:0] value,
   output logic        saturated
);

   logic [15:0] value_q, value_d;
   logic        carry;

   assign saturated = (value_q == 16'h9999);
   assign value     = value_q;

   always_comb begin
      value_d = value_q;
      carry   = 1'b1;
      if (clear) begin
         value_d = '0;
      end else if (inc && !saturated) begin
         // Ripple the increment through each digit, wrapping 9 -> 0.
         for (int i = 0; i < int'(BcdDigits); i++) begin
            if (carry) begin
               if (value_q[i*BcdDigitW +: BcdDigitW] == 4'd9) begin
                  value_d[i*BcdDigitW +: BcdDigitW] = 4'd0;
               end else begin
                  value_d[i*BcdDigitW +: BcdDigitW] = value_q[i*BcdDigitW +: BcdDigitW] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences pipe/bird renderers, detects crashes per frame
// and keeps BCD score and high score.
module game_sequencer import game_pkg::*; #(
   parameter int unsigned DEATH_FRAMES     = DefDeathFrames,
   parameter int unsigned OVER_HOLD_FRAMES = DefOverHoldFrames,
   parameter int unsigned FLOOR_Y          = DefFloorY,
   parameter int unsigned CEIL_Y           = DefCeilY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        btn_flap,
   input  logic        bird_pixel,
   input  logic        pipe_pixel,
   input  logic [9:0]  bird_y,
   input  logic        pipe_passed,
   output logic        pipe_reset,
   output logic        pipe_enable,
   output logic        bird_enable,
   output logic        bird_reset,
   output logic        flap_pulse,
   output logic [15:0] score_bcd,
   output logic [15:0] hiscore_bcd,
   output logic [1:0]  game_state
);

   localparam int unsigned CntMax =
      (DEATH_FRAMES > OVER_HOLD_FRAMES) ? DEATH_FRAMES : OVER_HOLD_FRAMES;
   localparam int unsigned CntW = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] DeathLast = CntW'(DEATH_FRAMES - 1);
   localparam logic [CntW-1:0] OverHold  = CntW'(OVER_HOLD_FRAMES);
   localparam logic [9:0]      FloorY    = 10'(FLOOR_Y);
   localparam logic [9:0]      CeilY     = 10'(CEIL_Y);

   game_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q, sync2_q, flap_prev_q, flap_edge;
   logic            coll_q, coll_now, crash;
   logic [15:0]     score, hiscore_q;
   logic            score_sat, score_clear, score_inc;

   assign flap_edge = sync2_q & ~flap_prev_q;
   assign coll_now  = (state_q == StPlaying) &&
                      ((bird_pixel && pipe_pixel) || (bird_y >= FloorY) || (bird_y <= CeilY));
   // The frame_tick cycle's own sample counts before the latch clears.
   assign crash       = frame_tick && (coll_q || coll_now);
   assign score_clear = (state_q == StIdle) && flap_edge;
   assign score_inc   = (state_q == StPlaying) && pipe_passed && !score_sat;

   assign score_bcd   = score;
   assign hiscore_bcd = hiscore_q;
   assign game_state  = state_q;

   bcd_counter4 u_score (
      .clk       (clk),
      .reset     (reset),
      .clear     (score_clear),
      .inc       (score_inc),
      .value     (score),
      .saturated (score_sat)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (flap_edge) state_d = StPlaying;
         end
         StPlaying: begin
            if (crash) begin
               state_d = StDying;
               cnt_d   = '0;
            end
         end
         StDying: begin
            if (frame_tick) begin
               if (cnt_q == DeathLast) begin
                  state_d = StGameOver;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StGameOver: begin
            // Early flaps are dropped; only a flap after the hold period restarts.
            if (flap_edge && (cnt_q == OverHold)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (frame_tick && (cnt_q < OverHold)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         flap_prev_q <= 1'b0;
         coll_q      <= 1'b0;
         hiscore_q   <= '0;
         flap_pulse  <= 1'b0;
         pipe_reset  <= 1'b1;
         bird_reset  <= 1'b1;
         pipe_enable <= 1'b0;
         bird_enable <= 1'b0;
      end else begin
         sync1_q     <= btn_flap;
         sync2_q     <= sync1_q;
         flap_prev_q <= sync2_q;
         coll_q      <= ((state_q == StPlaying) && !frame_tick) ? (coll_q | coll_now) : 1'b0;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flap_pulse  <= flap_edge && (state_q == StPlaying);
         if ((state_q == StDying) && (state_d == StGameOver) && bcd_gt(score, hiscore_q)) begin
            hiscore_q <= score;
         end
         unique case (state_d)
            StIdle: begin
               pipe_reset  <= 1'b1;
               bird_reset  <= 1'b1;
               pipe_enable <= 1'b0;
               bird_enable <= 1'b0;
            end
            StPlaying: begin
               pipe_reset  <= 1'b0;
               bird_reset  <= 1'b0;
               pipe_enable <= 1'b1;
               bird_enable <= 1'b1;
            end
            StDying: begin
               pipe_reset  <= 1'b0;
               bird_reset  <= 1'b0;
               pipe_enable <= 1'b0;
               bird_enable <= 1'b1;
            end
            default: begin
               pipe_reset  <= 1'b0;
               bird_reset  <= 1'b0;
               pipe_enable <= 1'b0;
               bird_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: reset, flap sync, scoring, crashes,
// death/game-over timing, high score and simultaneous-event corners.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick, btn_flap, bird_pixel, pipe_pixel, pipe_passed;
   logic [9:0]  bird_y;
   logic        pipe_reset, pipe_enable, bird_enable, bird_reset, flap_pulse;
   logic [15:0] score_bcd, hiscore_bcd;
   logic [1:0]  game_state;

   int checks   = 0;
   int failures = 0;

   game_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .btn_flap    (btn_flap),
      .bird_pixel  (bird_pixel),
      .pipe_pixel  (pipe_pixel),
      .bird_y      (bird_y),
      .pipe_passed (pipe_passed),
      .pipe_reset  (pipe_reset),
      .pipe_enable (pipe_enable),
      .bird_enable (bird_enable),
      .bird_reset  (bird_reset),
      .flap_pulse  (flap_pulse),
      .score_bcd   (score_bcd),
      .hiscore_bcd (hiscore_bcd),
      .game_state  (game_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic flap();
      btn_flap = 1'b1;
      step(5);
      btn_flap = 1'b0;
      step(4);
   endtask

   task automatic pass_pipes(input int n);
      for (int i = 0; i < n; i++) begin
         pipe_passed = 1'b1;
         step(1);
         pipe_passed = 1'b0;
         step(1);
      end
   endtask

   initial begin
      reset       = 1'b0;
      frame_tick  = 1'b0;
      btn_flap    = 1'b0;
      bird_pixel  = 1'b0;
      pipe_pixel  = 1'b0;
      pipe_passed = 1'b0;
      bird_y      = 10'd200;
      step(3);
      check_eq("rst_state", 16'(game_state), 16'd0);
      check_eq("rst_pipe_reset", 16'(pipe_reset), 16'd1);
      check_eq("rst_bird_reset", 16'(bird_reset), 16'd1);
      check_eq("rst_enables", 16'({pipe_enable, bird_enable}), 16'd0);
      check_eq("rst_score", score_bcd, 16'h0000);
      check_eq("rst_hiscore", hiscore_bcd, 16'h0000);
      check_eq("rst_flap_pulse", 16'(flap_pulse), 16'd0);

      reset = 1'b1;
      step(2);
      btn_flap = 1'b1;
      step(4);
      check_eq("start_state", 16'(game_state), 16'd1);
      check_eq("start_pipe_en", 16'(pipe_enable), 16'd1);
      check_eq("start_resets", 16'({pipe_reset, bird_reset}), 16'd0);
      step(1);
      btn_flap = 1'b0;
      step(4);

      // Flap while playing: one-cycle pulse, three cycles after the press.
      btn_flap = 1'b1;
      step(3);
      check_eq("flap_pulse_hi", 16'(flap_pulse), 16'd1);
      step(1);
      check_eq("flap_pulse_lo", 16'(flap_pulse), 16'd0);
      step(1);
      btn_flap = 1'b0;
      step(4);

      pass_pipes(12);
      check_eq("score_12", score_bcd, 16'h0012);

      bird_pixel = 1'b1;
      pipe_pixel = 1'b1;
      step(1);
      bird_pixel = 1'b0;
      pipe_pixel = 1'b0;
      step(3);
      check_eq("coll_wait_frame", 16'(game_state), 16'd1);
      frame_tick  = 1'b1;
      pipe_passed = 1'b1;
      step(1);
      frame_tick  = 1'b0;
      pipe_passed = 1'b0;
      check_eq("coll_dying", 16'(game_state), 16'd2);
      check_eq("dying_pipe_en", 16'(pipe_enable), 16'd0);
      check_eq("dying_bird_en", 16'(bird_enable), 16'd1);
      check_eq("coincident_pass", score_bcd, 16'h0013);
      pass_pipes(1);
      check_eq("dying_pass_ignored", score_bcd, 16'h0013);

      frames(59);
      check_eq("dying_59", 16'(game_state), 16'd2);
      frame();
      check_eq("over_state", 16'(game_state), 16'd3);
      check_eq("over_hiscore", hiscore_bcd, 16'h0013);

      frames(10);
      flap();
      check_eq("over_early_flap", 16'(game_state), 16'd3);
      frames(25);
      check_eq("over_no_queue", 16'(game_state), 16'd3);
      btn_flap = 1'b1;
      step(3);
      check_eq("over_to_idle", 16'(game_state), 16'd0);
      check_eq("idle_pipe_reset", 16'(pipe_reset), 16'd1);
      step(2);
      btn_flap = 1'b0;
      step(4);

      btn_flap = 1'b1;
      step(3);
      check_eq("replay_state", 16'(game_state), 16'd1);
      check_eq("replay_score", score_bcd, 16'h0000);
      check_eq("replay_hiscore", hiscore_bcd, 16'h0013);
      step(2);
      btn_flap = 1'b0;
      step(4);

      bird_y = 10'd469;
      frame();
      check_eq("floor_469", 16'(game_state), 16'd1);
      bird_y = 10'd470;
      frame();
      check_eq("floor_470", 16'(game_state), 16'd2);
      bird_y = 10'd200;

      frames(20);
      #2 reset = 1'b0;
      #1;
      check_eq("async_rst_state", 16'(game_state), 16'd0);
      check_eq("async_rst_hiscore", hiscore_bcd, 16'h0000);
      check_eq("async_rst_pipe_reset", 16'(pipe_reset), 16'd1);
      #2 reset = 1'b1;
      step(2);

      // Flap edge lands on a frame_tick with overlapping pixels.
      btn_flap = 1'b1;
      step(2);
      frame_tick = 1'b1;
      bird_pixel = 1'b1;
      pipe_pixel = 1'b1;
      step(1);
      frame_tick = 1'b0;
      bird_pixel = 1'b0;
      pipe_pixel = 1'b0;
      check_eq("simul_playing", 16'(game_state), 16'd1);
      step(2);
      btn_flap = 1'b0;
      step(4);
      frame();
      check_eq("simul_no_dying", 16'(game_state), 16'd1);

      pass_pipes(9999);
      check_eq("score_9999", score_bcd, 16'h9999);
      pass_pipes(1);
      check_eq("score_sat", score_bcd, 16'h9999);

      bird_y = 10'd0;
      frame();
      check_eq("ceil_dying", 16'(game_state), 16'd2);
      bird_y = 10'd200;
      frames(60);
      check_eq("sat_over", 16'(game_state), 16'd3);
      check_eq("sat_hiscore", hiscore_bcd, 16'h9999);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
